// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the round-robin stream multiplexer.
package stream_mux_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } mux_state_e;

  localparam int MODE_RR   = 0;
  localparam int MODE_PRIO = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin starting after ptr, or fixed priority
// (lowest index first), via a rotated double-width request vector.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int MODE     = MODE_RR,
  parameter int CW       = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CW-1:0]       ptr,
  output logic [CW-1:0]       gnt_idx,
  output logic                gnt_any
);

  localparam logic [CW:0] CH_W = (CW+1)'(CHANNELS);

  logic [2*CHANNELS-1:0] dbl_s;
  logic [CHANNELS-1:0]   rot_s;
  logic [CW-1:0]         start_s;
  logic [CW-1:0]         off_s;
  logic [CW:0]           sum_s;

  // scan start: channel after the last grant, or channel 0 in priority mode
  always_comb begin
    start_s = {CW{1'b0}};
    if (MODE == MODE_PRIO) begin
      start_s = {CW{1'b0}};
    end else if (ptr >= CW'(CHANNELS-1)) begin
      start_s = {CW{1'b0}};
    end else begin
      start_s = ptr + CW'(1);
    end
  end

  // rotate, priority-encode, then undo the rotation modulo CHANNELS
  always_comb begin
    dbl_s = {req, req};
    rot_s = dbl_s[start_s +: CHANNELS];
    off_s = {CW{1'b0}};
    for (int i = CHANNELS-1; i >= 0; i--) begin
      off_s = rot_s[i] ? CW'(i) : off_s;
    end
    sum_s   = {1'b0, start_s} + {1'b0, off_s};
    gnt_idx = (sum_s >= CH_W) ? CW'(sum_s - CH_W) : CW'(sum_s);
    gnt_any = |req;
  end

endmodule

// File: rtl/stream_mux_rr_chk.sv
// Handshake properties of the stream multiplexer output side.
module stream_mux_rr_chk #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int CW       = $clog2(CHANNELS)
) (
  input logic                clk,
  input logic                rst_n,
  input logic [CHANNELS-1:0] in_ready,
  input logic                out_valid,
  input logic                out_ready,
  input logic                out_last,
  input logic [WIDTH-1:0]    out_data,
  input logic [CW-1:0]       out_chan
);

  a_onehot_ready: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(in_ready));

  a_no_ready_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |-> (in_ready == {CHANNELS{1'b0}}));

  // a stalled beat must not change under the consumer
  a_hold_stalled: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)
                                   && $stable(out_last) && $stable(out_chan)));

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with packet locking and a
// registered output stage; merges filter-engine lines onto one bus.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int MODE     = MODE_RR,
  parameter int CW       = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [CW-1:0]             out_chan,
  input  logic                      out_ready
);

  mux_state_e            state_r;
  mux_state_e            state_nxt_s;
  logic [CW-1:0]         cur_r;
  logic [CW-1:0]         cur_nxt_s;
  logic [CW-1:0]         ptr_r;
  logic [CW-1:0]         ptr_nxt_s;
  logic [CW-1:0]         sel_s;
  logic [CHANNELS-1:0]   ready_s;
  logic                  accept_s;
  logic                  slot_free_s;
  logic [CW-1:0]         gnt_idx_s;
  logic                  gnt_any_s;
  logic [WIDTH-1:0]      data_r;
  logic                  valid_r;
  logic                  last_r;
  logic [CW-1:0]         chan_r;
  logic [WIDTH-1:0]      ch_data_s [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign ch_data_s[i] = in_data[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .MODE     (MODE),
    .CW       (CW)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_r),
    .gnt_idx (gnt_idx_s),
    .gnt_any (gnt_any_s)
  );

  assign slot_free_s = !valid_r || out_ready;

  // grant selection and packet-lock next state
  always_comb begin
    state_nxt_s = state_r;
    cur_nxt_s   = cur_r;
    ptr_nxt_s   = ptr_r;
    sel_s       = cur_r;
    ready_s     = {CHANNELS{1'b0}};
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        sel_s = gnt_idx_s;
        if (gnt_any_s && slot_free_s) begin
          ready_s[gnt_idx_s] = 1'b1;
          accept_s           = 1'b1;
          if (in_last[gnt_idx_s]) begin
            ptr_nxt_s = gnt_idx_s;
          end else begin
            state_nxt_s = LOCKED;
            cur_nxt_s   = gnt_idx_s;
          end
        end else begin
          accept_s = 1'b0;
        end
      end
      LOCKED: begin
        sel_s = cur_r;
        if (slot_free_s) begin
          ready_s[cur_r] = 1'b1;
          if (in_valid[cur_r]) begin
            accept_s = 1'b1;
            if (in_last[cur_r]) begin
              state_nxt_s = IDLE;
              ptr_nxt_s   = cur_r;
            end else begin
              state_nxt_s = LOCKED;
            end
          end else begin
            accept_s = 1'b0;
          end
        end else begin
          accept_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // no channel is offered the slot while reset is held
  assign in_ready = rst_n ? ready_s : {CHANNELS{1'b0}};

  // FSM state and arbitration pointers; ptr resets so channel 0 goes first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cur_r   <= {CW{1'b0}};
      ptr_r   <= CW'(CHANNELS-1);
    end else begin
      state_r <= state_nxt_s;
      cur_r   <= cur_nxt_s;
      ptr_r   <= ptr_nxt_s;
    end
  end

  // output register: load on accept, drain on out_ready, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      chan_r  <= {CW{1'b0}};
    end else if (accept_s) begin
      data_r  <= ch_data_s[sel_s];
      valid_r <= 1'b1;
      last_r  <= in_last[sel_s];
      chan_r  <= sel_s;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign out_data  = data_r;
  assign out_valid = valid_r;
  assign out_last  = last_r;
  assign out_chan  = chan_r;

  stream_mux_rr_chk #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .CW       (CW)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_chan  (out_chan)
  );

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed scenarios on MODE 0 and MODE 1 instances
// plus a randomized run against a transaction-level reference model.
module tb_stream_mux_rr;

  localparam int W = 32;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] in_last = '0;
  logic         out_ready = 1'b1;

  logic [N-1:0] rdy0, rdy1;
  logic [W-1:0] od0, od1;
  logic         ov0, ov1, ol0, ol1;
  logic [1:0]   oc0, oc1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(W), .CHANNELS(N), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy0), .out_data(od0), .out_valid(ov0),
    .out_last(ol0), .out_chan(oc0), .out_ready(out_ready));

  stream_mux_rr #(.WIDTH(W), .CHANNELS(N), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy1), .out_data(od1), .out_valid(ov1),
    .out_last(ol1), .out_chan(oc1), .out_ready(out_ready));

  // Reference model of the round-robin instance (dut0)
  bit           m_locked;
  int           m_owner;
  int           m_ptr;
  bit           m_ov;
  bit           m_ol;
  logic [W-1:0] m_od;
  int           m_oc;

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = N-1;
    m_ov = 0; m_ol = 0; m_od = '0; m_oc = 0;
  endtask

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int idx = (m_ptr + k) % N;
      if (in_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r = '0;
    int g;
    if (m_ov && !out_ready) return r;
    if (m_locked) r[m_owner] = 1'b1;
    else begin
      g = pick();
      if (g >= 0) r[g] = 1'b1;
    end
    return r;
  endfunction

  task automatic set_ch(input int c, input logic [W-1:0] d);
    in_data[c*W +: W] = d;
  endtask

  // one clock: capture the accepted beat, advance the model, return at negedge
  task automatic tick();
    logic [N-1:0] r;
    int acc;
    logic [W-1:0] d;
    bit lst;
    r = model_ready();
    acc = -1;
    for (int i = 0; i < N; i++) if (r[i] && in_valid[i]) acc = i;
    if (acc >= 0) begin
      d = in_data[acc*W +: W];
      lst = in_last[acc];
    end
    @(posedge clk);
    if (acc >= 0) begin
      m_ov = 1; m_od = d; m_ol = lst; m_oc = acc;
      if (lst) begin
        m_locked = 0; m_ptr = acc;
      end else begin
        m_locked = 1; m_owner = acc;
      end
    end else if (out_ready) begin
      m_ov = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
    for (int c = 0; c < N; c++) set_ch(c, 32'hD000_0000 + c);
    repeat (3) @(negedge clk);
    #1;
    total++; if (rdy0 !== 4'b0000) begin bad++; $display("FAIL reset_ready0 got=%b exp=%b", rdy0, 4'b0000); end
    total++; if (rdy1 !== 4'b0000) begin bad++; $display("FAIL reset_ready1 got=%b exp=%b", rdy1, 4'b0000); end
    total++; if ({ov0, ol0, oc0, od0} !== '0) begin bad++; $display("FAIL reset_outs got v=%b l=%b c=%0d d=%h exp zeros", ov0, ol0, oc0, od0); end
    rst_n = 1'b1;
    model_reset();
    #1;
    total++; if (rdy0 !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b exp=%b", rdy0, 4'b0001); end
  endtask

  task automatic test_rr_order();
    int exp_chan [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      total++; if (ov0 !== 1'b1 || oc0 !== exp_chan[i][1:0]) begin bad++; $display("FAIL rr_order[%0d] got v=%b chan=%0d exp v=1 chan=%0d", i, ov0, oc0, exp_chan[i]); end
      total++; if (od0 !== 32'hD000_0000 + exp_chan[i]) begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, od0, 32'hD000_0000 + exp_chan[i]); end
    end
  endtask

  task automatic test_packet_lock();
    in_valid = 4'b0110; in_last = 4'b0100;
    set_ch(1, 32'hA1); set_ch(2, 32'hC2);
    #1;
    total++; if (rdy0 !== 4'b0010) begin bad++; $display("FAIL lock_grant got=%b exp=%b", rdy0, 4'b0010); end
    tick(); set_ch(1, 32'hA2); #1;
    total++; if (rdy0 !== 4'b0010 || od0 !== 32'hA1) begin bad++; $display("FAIL lock_beat1 got rdy=%b d=%h exp rdy=0010 d=a1", rdy0, od0); end
    tick(); set_ch(1, 32'hA3); in_last[1] = 1'b1; #1;
    total++; if (rdy0 !== 4'b0010 || od0 !== 32'hA2) begin bad++; $display("FAIL lock_beat2 got rdy=%b d=%h exp rdy=0010 d=a2", rdy0, od0); end
    tick(); in_valid[1] = 1'b0; #1;
    total++; if (rdy0 !== 4'b0100 || od0 !== 32'hA3 || ol0 !== 1'b1 || oc0 !== 2'd1) begin bad++; $display("FAIL lock_beat3 got rdy=%b d=%h l=%b c=%0d exp rdy=0100 d=a3 l=1 c=1", rdy0, od0, ol0, oc0); end
    tick(); #1;
    total++; if (od0 !== 32'hC2 || oc0 !== 2'd2 || ov0 !== 1'b1) begin bad++; $display("FAIL lock_next got d=%h c=%0d v=%b exp d=c2 c=2 v=1", od0, oc0, ov0); end
    in_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    in_valid = 4'b0001; in_last = 4'b0001; set_ch(0, 32'h55);
    #1;
    total++; if (rdy0 !== 4'b0001) begin bad++; $display("FAIL bp_grant got=%b exp=%b", rdy0, 4'b0001); end
    tick();
    set_ch(0, 32'h66); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (od0 !== 32'h55 || ov0 !== 1'b1 || rdy0 !== 4'b0000) begin bad++; $display("FAIL bp_hold[%0d] got d=%h v=%b rdy=%b exp d=55 v=1 rdy=0000", i, od0, ov0, rdy0); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++; if (rdy0 !== 4'b0001) begin bad++; $display("FAIL bp_release_ready got=%b exp=%b", rdy0, 4'b0001); end
    tick(); #1;
    total++; if (od0 !== 32'h66 || ov0 !== 1'b1) begin bad++; $display("FAIL bp_no_bubble got d=%h v=%b exp d=66 v=1", od0, ov0); end
    in_valid = '0;
    tick();
  endtask

  task automatic test_bubbles();
    logic [N-1:0] vpat [6] = '{4'b1001, 4'b0001, 4'b0001, 4'b1001, 4'b1001, 4'b0001};
    logic [W-1:0] dpat [6] = '{32'h31, 32'h0, 32'h0, 32'h32, 32'h33, 32'h0};
    logic [N-1:0] lpat [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1001, 4'b0001};
    int bubbles = 0;
    int ch0_early = 0;
    bit seen_last3 = 0;
    set_ch(0, 32'h0B);
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 6) ? vpat[i] : 4'b0000;
      in_last  = (i < 6) ? lpat[i] : 4'b0001;
      set_ch(3, (i < 6) ? dpat[i] : 32'h0);
      #1;
      total++; if (rdy0 !== model_ready()) begin bad++; $display("FAIL bubble_ready[%0d] got=%b exp=%b", i, rdy0, model_ready()); end
      if (i >= 1 && i <= 5) begin
        if (!ov0) bubbles++;
        if (ov0 && oc0 == 2'd0 && !seen_last3) ch0_early++;
        if (ov0 && oc0 == 2'd3 && ol0) seen_last3 = 1;
      end
      tick();
    end
    total++; if (bubbles != 2) begin bad++; $display("FAIL bubble_count got=%0d exp=2", bubbles); end
    total++; if (ch0_early != 0 || !seen_last3) begin bad++; $display("FAIL bubble_no_interleave got early=%0d last3=%0d exp 0 1", ch0_early, seen_last3); end
  endtask

  task automatic test_prio();
    do_reset();
    in_valid = 4'b0101; in_last = 4'b0101;
    set_ch(0, 32'hC0); set_ch(2, 32'hC2);
    for (int i = 0; i < 8; i++) begin
      #1;
      total++; if (rdy1 !== 4'b0001) begin bad++; $display("FAIL prio_ready[%0d] got=%b exp=%b", i, rdy1, 4'b0001); end
      tick(); #1;
      total++; if (ov1 !== 1'b1 || oc1 !== 2'd0 || od1 !== 32'hC0) begin bad++; $display("FAIL prio_grant[%0d] got v=%b c=%0d d=%h exp v=1 c=0 d=c0", i, ov1, oc1, od1); end
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid_packet();
    in_valid = 4'b0010; in_last = 4'b0000; set_ch(1, 32'h11);
    tick(); set_ch(1, 32'h12);
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if (ov0 !== 1'b0 || rdy0 !== 4'b0000 || od0 !== '0 || oc0 !== 2'd0 || ol0 !== 1'b0) begin bad++; $display("FAIL midrst_async got v=%b rdy=%b d=%h c=%0d l=%b exp zeros", ov0, rdy0, od0, oc0, ol0); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    in_valid = 4'b0011; in_last = 4'b0011; set_ch(0, 32'h100);
    #1;
    total++; if (rdy0 !== 4'b0001) begin bad++; $display("FAIL midrst_restart got=%b exp=%b", rdy0, 4'b0001); end
    tick(); #1;
    total++; if (ov0 !== 1'b1 || oc0 !== 2'd0 || od0 !== 32'h100) begin bad++; $display("FAIL midrst_first got v=%b c=%0d d=%h exp v=1 c=0 d=100", ov0, oc0, od0); end
    in_valid = '0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = N'($urandom_range(0, 15));
      in_last   = N'($urandom & $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++) set_ch(c, $urandom);
      #1;
      total++; if (rdy0 !== model_ready()) begin bad++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, rdy0, model_ready()); end
      total++; if (ov0 !== m_ov) begin bad++; $display("FAIL rand_valid[%0d] got=%b exp=%b", i, ov0, m_ov); end
      if (m_ov) begin
        total++; if (od0 !== m_od || ol0 !== m_ol || oc0 !== m_oc[1:0]) begin bad++; $display("FAIL rand_beat[%0d] got d=%h l=%b c=%0d exp d=%h l=%b c=%0d", i, od0, ol0, oc0, m_od, m_ol, m_oc); end
      end
      tick();
    end
    out_ready = 1'b1;
    in_valid = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rr_order();
    test_packet_lock();
    test_backpressure();
    test_bubbles();
    test_prio();
    test_reset_mid_packet();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
